// File: rtl/seg_scan_if.sv
// Segment-bus handshake between the digit source (master) and the scan driver (slave).
interface seg_scan_if;
  logic [15:0] power_level_7seg_output;
  logic        display_en;
  logic [7:0]  seg_out;
  logic [1:0]  dig_sel;
  logic        frame_tick;

  modport master (
    output power_level_7seg_output, display_en,
    input  seg_out, dig_sel, frame_tick
  );
  modport slave (
    input  power_level_7seg_output, display_en,
    output seg_out, dig_sel, frame_tick
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Two-digit 7-segment scan driver: blank/show slots per digit, one snapshot per frame,
// registered active-low outputs aligned with the FSM state.
module seg_scan_driver #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        async_reset,
  seg_scan_if.slave   bus
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - BLANK_CYCLES - 1);

  // Encoding chosen so that state+1 walks the cycle and bit0 marks SHOW slots.
  localparam logic [1:0] S_BLANK0 = 2'd0;
  localparam logic [1:0] S_SHOW0  = 2'd1;
  localparam logic [1:0] S_BLANK1 = 2'd2;
  localparam logic [1:0] S_SHOW1  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   snap_q, snap_d;
  logic [7:0]    seg_q, seg_d;
  logic [1:0]    dig_q, dig_d;
  logic          tick_q, tick_d;
  logic          slot_end;

  always_comb begin
    slot_end = state_q[0] ? (cnt_q == SHOW_LAST) : (cnt_q == BLANK_LAST);
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    snap_d   = snap_q;
    tick_d   = 1'b0;
    if (slot_end) begin
      state_d = state_q + 2'd1;
      cnt_d   = '0;
      if (state_q == S_BLANK0) begin
        snap_d = bus.power_level_7seg_output;
        tick_d = 1'b1;
      end
    end
    // Outputs are decoded from the next state so they change on the same edge.
    seg_d = 8'hFF;
    dig_d = 2'b11;
    if (bus.display_en) begin
      case (state_d)
        S_SHOW0: begin seg_d = snap_d[7:0];  dig_d = 2'b10; end
        S_SHOW1: begin seg_d = snap_d[15:8]; dig_d = 2'b01; end
        default: begin seg_d = 8'hFF;        dig_d = 2'b11; end
      endcase
    end
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state_q <= S_BLANK0;
      cnt_q   <= '0;
      snap_q  <= 16'hFFFF;
      seg_q   <= 8'hFF;
      dig_q   <= 2'b11;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.dig_sel    = dig_q;
  assign bus.frame_tick = tick_q;
endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter: SCAN_DIV, 50000, clock cycles per digit slot, blanking included.
REQ-002 Parameter: BLANK_CYCLES, 16, leading blank cycles per slot for anti-ghosting.
REQ-003 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port: async_reset  input  1  reset, asynchronous, active-high.
REQ-005 Port: power_level_7seg_output  input  16  two-digit segment bus {digit1[7:0], digit0[7:0]}; bit 7 = dp; active-low (0 = segment lit).
REQ-006 Port: display_en  input  1  1 = drive display, 0 = force blank.
REQ-007 Port: seg_out  output  8  shared segment lines, active-low.
REQ-008 Port: dig_sel  output  2  digit enables, active-low; bit0 = digit0, bit1 = digit1.
REQ-009 Port: frame_tick  output  1  one-cycle pulse at the start of each displayed frame.

Function
REQ-010 Block SHALL time-multiplex the two-digit bus onto one physical segment bus with per-digit enables.
REQ-011 FSM SHALL have exactly four states, cycling BLANK0 -> SHOW0 -> BLANK1 -> SHOW1 -> BLANK0.
REQ-012 Each BLANK state SHALL last exactly BLANK_CYCLES cycles; each SHOW state SHALL last exactly SCAN_DIV-BLANK_CYCLES cycles; frame = 2*SCAN_DIV cycles.
REQ-013 Slot counter SHALL be $clog2(SCAN_DIV) bits wide and clear to 0 on every state transition.
REQ-014 Snapshot register (16 bits) SHALL load power_level_7seg_output only on the BLANK0->SHOW0 transition edge; no other load point.
REQ-015 Both digits within one frame SHALL come from the same snapshot; bus changes mid-frame SHALL NOT appear until the next frame.
REQ-016 In SHOW0: seg_out = snapshot[7:0], dig_sel = 2'b10.
REQ-017 In SHOW1: seg_out = snapshot[15:8], dig_sel = 2'b01.
REQ-018 In BLANK0/BLANK1: seg_out = 8'hFF, dig_sel = 2'b11.
REQ-019 seg_out, dig_sel and frame_tick SHALL be registered and update on the same edge as the state change they reflect (no output lag vs. state).
REQ-020 frame_tick SHALL be 1 only during the first cycle of SHOW0, independent of display_en.
REQ-021 display_en = 0 SHALL force seg_out = 8'hFF, dig_sel = 2'b11 from the next clock edge; FSM, counter and snapshot SHALL keep running.
REQ-022 display_en reasserted mid-SHOW SHALL drive the current digit from the next edge for the rest of that slot.
REQ-023 dig_sel SHALL never be 2'b00 in any cycle, including across transitions.
REQ-024 Constraint: BLANK_CYCLES >= 1 and SCAN_DIV > BLANK_CYCLES; other values unsupported.

Reset
REQ-025 async_reset = 1 SHALL immediately, without a clock edge, set state = BLANK0, counter = 0, snapshot = 16'hFFFF, seg_out = 8'hFF, dig_sel = 2'b11, frame_tick = 0.
REQ-026 After release, first rising edge SHALL start counter from 0 in BLANK0; first snapshot loads at the end of that BLANK0.
REQ-027 Reset asserted mid-operation (any state) SHALL abandon the current frame; no partial digit is displayed after release.

Verification (SCAN_DIV = 8, BLANK_CYCLES = 2, frame = 16 cycles)
REQ-028 Reset hold, bus = 16'h0000 -> seg_out = FF, dig_sel = 11, frame_tick = 0 throughout reset and for 2 cycles after release.
REQ-029 Release, bus = 16'hC0F9, display_en = 1 -> cycles 0-1 FF/11; cycles 2-7 F9/10 with frame_tick = 1 on cycle 2 only; cycles 8-9 FF/11; cycles 10-15 C0/01; repeats every 16.
REQ-030 Bus changed to 16'hA4B0 on cycle 4 (inside SHOW0) -> cycles 10-15 still C0/01; next frame shows B0/10 then A4/01.
REQ-031 display_en = 0 at cycle 20 -> FF/11 from cycle 21 onward; frame_tick still pulses at cycles 18, 34, 50; re-enable during SHOW1 shows snapshot[15:8] from next edge.
REQ-032 async_reset pulsed mid-SHOW1 (between edges) -> outputs FF/11 before next edge; after release sequence restarts per REQ-029 timing with fresh snapshot.
REQ-033 Assertion over all runs: dig_sel != 00; each digit enable preceded by >= 2 blank cycles.
